// File: rtl/wb_bus_router.sv
// rtl/wb_bus_router.sv - Wishbone classic-cycle router with unmapped/timeout error responses and abort handling
module wb_bus_router #(
    parameter int NUM_SLAVES     = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int SEL_BITS       = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wb_stb_i,
    input  logic                             wb_cyc_i,
    input  logic                             wb_we_i,
    input  logic [ADDR_WIDTH-1:0]            wb_adr_i,
    input  logic [DATA_WIDTH-1:0]            wb_dat_i,
    output logic [DATA_WIDTH-1:0]            wb_dat_o,
    output logic                             wb_ack_o,
    output logic                             wb_err_o,
    output logic [NUM_SLAVES-1:0]            s_wb_stb_o,
    output logic [NUM_SLAVES-1:0]            s_wb_cyc_o,
    output logic                             s_wb_we_o,
    output logic [ADDR_WIDTH-SEL_BITS-1:0]   s_wb_adr_o,
    output logic [DATA_WIDTH-1:0]            s_wb_dat_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_wb_dat_i,
    input  logic [NUM_SLAVES-1:0]            s_wb_ack_i,
    output logic [7:0]                       err_count
);
    localparam int LOC_W = ADDR_WIDTH - SEL_BITS;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RESPOND, S_HOLD} state_t;

    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic                    we_q, we_d;
    logic [LOC_W-1:0]        adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    logic [SEL_BITS-1:0]     idx;
    logic                    ack_sel;
    logic [DATA_WIDTH-1:0]   slv_rdata;

    assign idx     = wb_adr_i[ADDR_WIDTH-1 -: SEL_BITS];
    assign ack_sel = |(s_wb_ack_i & sel_q);

    always_comb begin
        slv_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_q[k]) begin
                slv_rdata = slv_rdata | s_wb_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        we_d      = we_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    we_d   = wb_we_i;
                    adr_d  = wb_adr_i[LOC_W-1:0];
                    wdat_d = wb_dat_i;
                    if (32'(idx) < NUM_SLAVES) begin
                        for (int k = 0; k < NUM_SLAVES; k++) begin
                            sel_d[k] = (32'(idx) == k);
                        end
                        cnt_d   = '0;
                        state_d = S_ACTIVE;
                    end else begin
                        err_d   = 1'b1;
                        rdat_d  = '0;
                        state_d = S_RESPOND;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            S_ACTIVE: begin
                // A master abort beats any ack in the same cycle: no response is owed.
                if (!wb_cyc_i) begin
                    sel_d   = '0;
                    state_d = S_IDLE;
                end else if (ack_sel) begin
                    sel_d   = '0;
                    err_d   = 1'b0;
                    rdat_d  = we_q ? '0 : slv_rdata;
                    state_d = S_RESPOND;
                end else if (cnt_q == CNT_LAST) begin
                    sel_d   = '0;
                    err_d   = 1'b1;
                    rdat_d  = '0;
                    state_d = S_RESPOND;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // HOLD lets the master's trailing stb drain before IDLE samples again.
            S_RESPOND: state_d = S_HOLD;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            rdat_q    <= rdat_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign wb_ack_o   = (state_q == S_RESPOND) && !err_q;
    assign wb_err_o   = (state_q == S_RESPOND) && err_q;
    assign wb_dat_o   = rdat_q;
    assign s_wb_stb_o = sel_q;
    assign s_wb_cyc_o = sel_q;
    assign s_wb_we_o  = we_q;
    assign s_wb_adr_o = adr_q;
    assign s_wb_dat_o = wdat_q;
    assign err_count  = err_cnt_q;
endmodule
